// File: rtl/mem_access_unit.sv
// MEM-stage load/store controller: byte/halfword/word accesses on a word-organised
// data memory, with load extension and read-modify-write for sub-word stores.
module mem_access_unit #(
    parameter int NB_DATA  = 32,
    parameter int NB_ADDR  = 7,
    parameter int NB_BADDR = 32
) (
    input  logic                i_clock,
    input  logic                rstb,
    input  logic                i_valid,
    input  logic                i_mem_read,
    input  logic                i_mem_write,
    input  logic [1:0]          i_size,
    input  logic                i_unsigned,
    input  logic [NB_BADDR-1:0] i_addr,
    input  logic [NB_DATA-1:0]  i_wdata,
    output logic                o_ready,
    output logic [NB_DATA-1:0]  o_rdata,
    output logic                o_rdata_valid,
    output logic                o_fault,
    output logic [NB_ADDR-1:0]  o_mem_read_addr,
    output logic [NB_ADDR-1:0]  o_mem_write_addr,
    output logic [NB_DATA-1:0]  o_mem_data,
    output logic                o_mem_read_enable,
    output logic                o_mem_write_enable,
    input  logic [NB_DATA-1:0]  i_mem_data,
    output logic [1:0]          o_dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_LOAD = 2'b01;
    localparam logic [1:0] ST_RMW  = 2'b10;

    logic [1:0]         state_q, state_d;
    logic [NB_ADDR-1:0] idx_q, idx_d;
    logic [1:0]         off_q, off_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic [15:0]        wdata_q, wdata_d;
    logic [NB_DATA-1:0] rdata_q, rdata_d;
    logic               rdata_valid_q, rdata_valid_d;
    logic               fault_q, fault_d;

    logic               is_idle, accept, req_fault;
    logic               do_load, do_word_store, do_sub_store;
    logic [NB_ADDR-1:0] req_idx;
    logic [7:0]         lane_b;
    logic [15:0]        lane_h;
    logic [NB_DATA-1:0] load_ext, merged;

    // Handshake: a request is taken in any cycle where i_valid and o_ready are both
    // high and reset is low; inputs are ignored in every other cycle.
    assign is_idle = (state_q == ST_IDLE);
    assign accept  = i_valid & is_idle & ~rstb;
    assign req_idx = i_addr[NB_ADDR+1:2];

    // A request with neither read nor write is a no-op, so it never faults.
    assign req_fault = (i_mem_read | i_mem_write) &
                       ((i_mem_read & i_mem_write) |
                        (i_size == 2'b11) |
                        ((i_size == 2'b01) & i_addr[0]) |
                        ((i_size == 2'b10) & (|i_addr[1:0])) |
                        (|i_addr[NB_BADDR-1:NB_ADDR+2]));

    assign do_load       = accept & ~req_fault & i_mem_read;
    assign do_word_store = accept & ~req_fault & i_mem_write & (i_size == 2'b10);
    assign do_sub_store  = accept & ~req_fault & i_mem_write & (i_size != 2'b10);

    always_comb begin
        lane_b = i_mem_data[{off_q, 3'b000} +: 8];
        lane_h = off_q[1] ? i_mem_data[31:16] : i_mem_data[15:0];
        case (size_q)
            2'b00:   load_ext = {{24{~uns_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{~uns_q & lane_h[15]}}, lane_h};
            default: load_ext = i_mem_data;
        endcase
    end

    always_comb begin
        merged = i_mem_data;
        if (size_q == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else if (off_q[1]) begin
            merged[31:16] = wdata_q;
        end else begin
            merged[15:0] = wdata_q;
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        off_d         = off_q;
        size_d        = size_q;
        uns_d         = uns_q;
        wdata_d       = wdata_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        fault_d       = accept & req_fault;
        case (state_q)
            ST_IDLE: begin
                if (do_load || do_sub_store) begin
                    idx_d   = req_idx;
                    off_d   = i_addr[1:0];
                    size_d  = i_size;
                    uns_d   = i_unsigned;
                    wdata_d = i_wdata[15:0];
                    state_d = do_load ? ST_LOAD : ST_RMW;
                end
            end
            ST_LOAD: begin
                rdata_d       = load_ext;
                rdata_valid_d = 1'b1;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (rstb) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            off_q         <= '0;
            size_q        <= '0;
            uns_q         <= 1'b0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            off_q         <= off_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            fault_q       <= fault_d;
        end
    end

    assign o_ready            = is_idle;
    assign o_rdata            = rdata_q;
    assign o_rdata_valid      = rdata_valid_q;
    assign o_fault            = fault_q;
    assign o_dbg_state        = state_q;
    assign o_mem_read_addr    = req_idx;
    assign o_mem_read_enable  = do_load | do_sub_store;
    assign o_mem_write_enable = do_word_store | ((state_q == ST_RMW) & ~rstb);
    assign o_mem_write_addr   = (state_q == ST_RMW) ? idx_q : req_idx;
    assign o_mem_data         = (state_q == ST_RMW) ? merged : i_wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: a word memory, a byte-level reference model
// of memory contents and load results, and a per-cycle compare process.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rstb;
    logic        i_valid, i_mem_read, i_mem_write, i_unsigned;
    logic [1:0]  i_size;
    logic [31:0] i_addr, i_wdata;
    logic        o_ready, o_rdata_valid, o_fault;
    logic [31:0] o_rdata, o_mem_data, mem_rd_q;
    logic [6:0]  o_mem_read_addr, o_mem_write_addr;
    logic        o_mem_read_enable, o_mem_write_enable;
    logic [1:0]  o_dbg_state;

    logic        init_mem;
    logic [31:0] dmem [128];
    logic [31:0] ref_mem [128];
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] exp_q [$];
    int          exp_cyc_q [$];
    int          fault_cyc_q [$];
    logic [31:0] last_rdata = 32'h0;
    logic [31:0] v;

    localparam logic [31:0] INIT_W1 = 32'h80FF7F01;
    localparam logic [31:0] INIT_W2 = 32'h11223344;

    mem_access_unit dut (
        .i_clock(clk), .rstb(rstb), .i_valid(i_valid), .i_mem_read(i_mem_read),
        .i_mem_write(i_mem_write), .i_size(i_size), .i_unsigned(i_unsigned),
        .i_addr(i_addr), .i_wdata(i_wdata), .o_ready(o_ready), .o_rdata(o_rdata),
        .o_rdata_valid(o_rdata_valid), .o_fault(o_fault),
        .o_mem_read_addr(o_mem_read_addr), .o_mem_write_addr(o_mem_write_addr),
        .o_mem_data(o_mem_data), .o_mem_read_enable(o_mem_read_enable),
        .o_mem_write_enable(o_mem_write_enable), .i_mem_data(mem_rd_q),
        .o_dbg_state(o_dbg_state)
    );

    // Clock/reset and the data memory (read data one cycle after the strobe)
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) dmem[i] <= 32'h0;
            dmem[1] <= INIT_W1;
            dmem[2] <= INIT_W2;
        end else begin
            if (o_mem_read_enable) mem_rd_q <= dmem[o_mem_read_addr];
            if (o_mem_write_enable) dmem[o_mem_write_addr] <= o_mem_data;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Reference model: memory as bytes, faults from alignment/range rules
    function automatic logic model_fault(input logic rd, input logic wr,
                                         input logic [1:0] size, input logic [31:0] addr);
        int nbytes;
        if (!rd && !wr) return 1'b0;
        if (rd && wr) return 1'b1;
        if (size == 2'd3) return 1'b1;
        nbytes = 1 << size;
        if ((addr % nbytes) != 0) return 1'b1;
        return addr >= 32'd512;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                               input logic [31:0] addr);
        logic [31:0] w;
        w = ref_mem[addr / 4] >> (8 * (addr % 4));
        if (size == 2'd0) return uns ? 32'(w[7:0]) : 32'($signed(w[7:0]));
        if (size == 2'd1) return uns ? 32'(w[15:0]) : 32'($signed(w[15:0]));
        return w;
    endfunction

    task automatic model_store(input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wdata);
        logic [31:0] mask;
        int sh;
        mask = (size == 2'd0) ? 32'hFF : (size == 2'd1) ? 32'hFFFF : 32'hFFFFFFFF;
        sh   = 8 * (addr % 4);
        ref_mem[addr / 4] = (ref_mem[addr / 4] & ~(mask << sh)) | ((wdata & mask) << sh);
    endtask

    // Driver: one request, strobes checked in the accept cycle and the cycle after
    task automatic req(input logic rd, input logic wr, input logic [1:0] size,
                       input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] mv);
        int waited = 0;
        int t;
        logic f;
        logic [6:0] idx;
        mv  = 32'h0;
        idx = addr[8:2];
        @(posedge clk); #1;
        while (!o_ready && waited < 10) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!o_ready) begin
            check("ready_timeout", 32'(o_ready), 32'h1);
            return;
        end
        i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_size = size;
        i_unsigned = uns; i_addr = addr; i_wdata = wdata;
        t = cyc;
        f = model_fault(rd, wr, size, addr);
        @(negedge clk);
        if (f) begin
            check("fault_no_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h0);
            fault_cyc_q.push_back(t + 1);
        end else if (rd) begin
            check("load_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h2);
            check("load_raddr", 32'(o_mem_read_addr), 32'(idx));
            mv = model_load(size, uns, addr);
            exp_q.push_back(mv);
            exp_cyc_q.push_back(t + 2);
        end else if (wr && size == 2'd2) begin
            check("sw_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h1);
            check("sw_waddr", 32'(o_mem_write_addr), 32'(idx));
            check("sw_data", o_mem_data, wdata);
            model_store(size, addr, wdata);
        end else if (wr) begin
            check("rmw_read_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h2);
            check("rmw_raddr", 32'(o_mem_read_addr), 32'(idx));
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        if (!f && (rd || (wr && size != 2'd2))) begin
            check("busy_not_ready", 32'(o_ready), 32'h0);
            @(negedge clk);
            if (wr) begin
                model_store(size, addr, wdata);
                check("rmw_write_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h1);
                check("rmw_waddr", 32'(o_mem_write_addr), 32'(idx));
                check("rmw_data", o_mem_data, ref_mem[idx]);
            end else begin
                check("load_wait_no_strobe", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h0);
            end
        end else begin
            check("ready_after_1cyc", 32'(o_ready), 32'h1);
        end
    endtask

    // Compare process: registered outputs against the expected queues every cycle
    always @(negedge clk) begin
        if (rstb) begin
            check("reset_strobes", {30'h0, o_mem_read_enable, o_mem_write_enable}, 32'h0);
            last_rdata = 32'h0;
        end else begin
            if (o_fault || o_rdata_valid)
                check("fault_valid_excl", 32'(o_fault & o_rdata_valid), 32'h0);
            if (o_rdata_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rdata_valid", 32'h1, 32'h0);
                end else begin
                    last_rdata = exp_q.pop_front();
                    check("rdata", o_rdata, last_rdata);
                    check("rdata_latency", 32'(cyc), 32'(exp_cyc_q.pop_front()));
                end
            end else begin
                check("rdata_hold", o_rdata, last_rdata);
            end
            if (o_fault) begin
                if (fault_cyc_q.size() == 0) check("unexpected_fault", 32'h1, 32'h0);
                else check("fault_cycle", 32'(cyc), 32'(fault_cyc_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rstb = 1'b1; init_mem = 1'b1;
        i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0; i_size = 2'd0;
        i_unsigned = 1'b0; i_addr = 32'h0; i_wdata = 32'h0;
        for (int i = 0; i < 128; i++) ref_mem[i] = 32'h0;
        ref_mem[1] = INIT_W1;
        ref_mem[2] = INIT_W2;
        repeat (2) @(posedge clk);
        #1;
        // A load presented during reset must be ignored
        i_valid = 1'b1; i_mem_read = 1'b1; i_size = 2'd2; i_addr = 32'h10;
        @(posedge clk); #1;
        i_valid = 1'b0; i_mem_read = 1'b0; init_mem = 1'b0;
        check("reset_ready", 32'(o_ready), 32'h1);
        check("reset_rdata", o_rdata, 32'h0);
        check("reset_flags", {30'h0, o_rdata_valid, o_fault}, 32'h0);
        rstb = 1'b0;

        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, v);
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, v);
        check("model_lw_10", v, 32'hDEADBEEF);
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h07, 32'h0, v);
        check("model_lb_07", v, 32'hFFFFFF80);
        req(1'b1, 1'b0, 2'd0, 1'b1, 32'h07, 32'h0, v);
        check("model_lbu_07", v, 32'h00000080);
        req(1'b1, 1'b0, 2'd0, 1'b0, 32'h05, 32'h0, v);
        check("model_lb_05", v, 32'h0000007F);
        req(1'b1, 1'b0, 2'd1, 1'b1, 32'h06, 32'h0, v);
        check("model_lhu_06", v, 32'h000080FF);
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h04, 32'h0, v);
        check("model_lh_04", v, 32'h00007F01);

        req(1'b0, 1'b1, 2'd1, 1'b0, 32'h0A, 32'h0000ABCD, v);
        req(1'b1, 1'b0, 2'd1, 1'b0, 32'h0A, 32'h0, v);
        check("model_lh_0a", v, 32'hFFFFABCD);
        check("mem2_after_sh", dmem[2], 32'hABCD3344);

        req(1'b0, 1'b1, 2'd0, 1'b0, 32'h13, 32'h1234565A, v);
        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, v);
        check("model_lw_after_sb", v, 32'h5AADBEEF);

        req(1'b1, 1'b0, 2'd2, 1'b0, 32'h02, 32'h0, v);
        req(1'b0, 1'b1, 2'd1, 1'b0, 32'h03, 32'h0000FFFF, v);
        req(1'b0, 1'b1, 2'd2, 1'b0, 32'h200, 32'hCAFEF00D, v);

        // Reset while the sub-word store sits between its read and its write
        @(posedge clk); #1;
        i_valid = 1'b1; i_mem_write = 1'b1; i_size = 2'd0; i_addr = 32'h04; i_wdata = 32'hAA;
        @(negedge clk);
        check("rmw_abort_read", 32'(o_mem_read_enable), 32'h1);
        @(posedge clk); #1;
        i_valid = 1'b0; i_mem_write = 1'b0; rstb = 1'b1;
        @(negedge clk);
        check("rmw_abort_no_write", 32'(o_mem_write_enable), 32'h0);
        @(posedge clk); #1;
        check("abort_ready", 32'(o_ready), 32'h1);
        check("abort_rdata", o_rdata, 32'h0);
        check("abort_flags", {30'h0, o_rdata_valid, o_fault}, 32'h0);
        rstb = 1'b0;
        check("mem1_after_abort", dmem[1], INIT_W1);

        req(1'b0, 1'b1, 2'd0, 1'b0, 32'h0C, 32'h00000055, v);
        req(1'b1, 1'b0, 2'd0, 1'b1, 32'h0C, 32'h0, v);
        check("model_lbu_0c", v, 32'h00000055);

        repeat (4) @(posedge clk);
        #1;
        check("pending_loads", 32'(exp_q.size()), 32'h0);
        check("pending_faults", 32'(fault_cyc_q.size()), 32'h0);
        for (int i = 0; i < 128; i++) begin
            if (dmem[i] !== ref_mem[i]) check("mem_final", dmem[i], ref_mem[i]);
        end
        check("mem_final_w4", dmem[4], ref_mem[4]);
        check("mem_final_w0", dmem[0], 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store controller in the MEM stage, between the pipeline's EX/MEM register and the word-organised data memory. It turns byte-addressed byte, halfword and word accesses into word accesses, with sign or zero extension for loads. Sub-word stores use a two-cycle read-modify-write, because the data memory has no byte enables. It also flags misaligned or out-of-range requests instead of issuing them.

## Interface
- NB_DATA, 32, data word width (fixed at 32; lane logic assumes 4 bytes)
- NB_ADDR, 7, data memory word-address width (depth 2^NB_ADDR)
- NB_BADDR, 32, CPU byte-address width
- i_clock  in  1  clock; all state on rising edge
- rstb  in  1  reset, synchronous, active-high
- i_valid  in  1  request present
- i_mem_read  in  1  load request
- i_mem_write  in  1  store request
- i_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- i_unsigned  in  1  zero-extend load (LBU/LHU); else sign-extend
- i_addr  in  NB_BADDR  byte address
- i_wdata  in  NB_DATA  store data, right-justified
- o_ready  out  1  unit idle, request accepted this cycle if i_valid
- o_rdata  out  NB_DATA  extended load result
- o_rdata_valid  out  1  one-cycle pulse, o_rdata valid
- o_fault  out  1  one-cycle pulse, request rejected
- o_mem_read_addr  out  NB_ADDR  word read address
- o_mem_write_addr  out  NB_ADDR  word write address
- o_mem_data  out  NB_DATA  write data to memory
- o_mem_read_enable  out  1  memory read strobe
- o_mem_write_enable  out  1  memory write strobe
- i_mem_data  in  NB_DATA  memory read data, valid 1 cycle after read strobe (low-latency mode)

## Operation
- Word index = i_addr[NB_ADDR+1:2].
- Lanes are little-endian: byte n = bits [8n+7:8n] with n = addr[1:0]; halfword = [15:0] if addr[1]=0, else [31:16].
- Accept = i_valid & o_ready & !rstb.
- Fault conditions, checked on accept:
  - both read and write set
  - i_size=11
  - halfword with addr[0]=1
  - word with addr[1:0]≠0
  - i_addr[NB_BADDR-1:NB_ADDR+2]≠0
- On fault: no memory strobe, o_fault=1 next cycle, state stays IDLE. Request with neither read nor write set: accepted as no-op.
- FSM states:
  - IDLE: o_ready=1.
    - Word store: drives write_enable, write_addr, o_mem_data=i_wdata combinationally; stays IDLE.
    - Load: drives read_enable and read_addr; latches offset, size and unsigned; goes to LOAD.
    - Sub-word store: drives read_enable; latches word index, offset, size and wdata; goes to RMW.
  - LOAD: extracts the lane from i_mem_data and extends it to 32 bits (bit 7 or bit 15 for sign); registers it into o_rdata; sets o_rdata_valid next cycle; goes to IDLE.
  - RMW: replaces the addressed lane of i_mem_data with the latched wdata[7:0] or [15:0]. Drives write_enable=1 with the merged word, write_addr = latched index; goes to IDLE.
- o_ready=0 in LOAD and RMW. The pipeline must hold inputs stable or stall; inputs are ignored outside IDLE.
- Word load extension is a pass-through.

## Timing
- Reset values: state IDLE, o_rdata=0, o_rdata_valid=0, o_fault=0.
- While rstb=1, both memory strobes are forced 0. Reset in LOAD or RMW aborts the operation, with no write and no valid pulse.
- Word store: strobe in accept cycle T; memory updated at edge ending T; 1-cycle occupancy.
- Load accepted at T:
  - read strobe in T
  - i_mem_data valid in T+1 (LOAD)
  - o_rdata/o_rdata_valid high in T+2; o_ready high again in T+1 → T+2 (IDLE in T+2)
  - back-to-back loads: one per 2 cycles
- Sub-word store accepted at T: read in T, merged write strobe in T+1, IDLE at T+2. A load to the same word accepted at T+2 sees the merged value.
- o_rdata holds its value until the next load completes; o_fault and o_rdata_valid are never high together.

## Test plan
- Word store then load: store 0xDEADBEEF @0x10, load word @0x10 → o_rdata=0xDEADBEEF, valid at T+2.
- Byte loads with extension:
  - mem[1]=0x80FF7F01, LB @0x07 → 0xFFFFFF80
  - LBU @0x07 → 0x00000080
  - LB @0x05 → 0x0000007F
- Halfword RMW: mem[2]=0x11223344, SH 0xABCD @0x0A → mem[2]=0xABCD3344. Write strobe only in T+1; LH @0x0A → 0xFFFFABCD.
- Faults: LW @0x02, SH @0x03, SW @0x200 (range) → o_fault pulse, no strobes, mem unchanged, o_ready stays 1.
- Reset mid-RMW: SB @0x04, rstb=1 in T+1 → no write strobe, mem[1] unchanged, outputs zero, IDLE.
- Back-to-back: SB 0x55 @0x0C, then immediately LBU @0x0C when ready → 0x00000055.
